// File: rtl/spu_pkg.sv
// Shared definitions for the SPU issue front end.
//   - Architectural widths (instruction word, opcode, register address, register count).
//   - Bit positions of each field inside the 32-bit instruction word.
//   - decoded_instr_t: the split form of an instruction word.
//   - decode_instr(): splits a raw word into decoded_instr_t. Bits [3:0] are reserved
//     and are not decoded.
package spu_pkg;

    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned OPCODE_W   = 6;
    localparam int unsigned REG_ADDR_W = 7;
    localparam int unsigned NUM_REGS   = 128;

    // Field positions (LSB of each field)
    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned IMMSEL_BIT = 25;
    localparam int unsigned RD_LSB     = 18;
    localparam int unsigned RA_LSB     = 11;
    localparam int unsigned RB_LSB     = 4;

    typedef struct packed {
        logic                  immeSel;
        logic [OPCODE_W-1:0]   opCode;
        logic [REG_ADDR_W-1:0] ra;
        logic [REG_ADDR_W-1:0] rb;
        logic [REG_ADDR_W-1:0] rd;
    } decoded_instr_t;

    function automatic decoded_instr_t decode_instr(input logic [INSTR_W-1:0] word);
        decoded_instr_t d;
        d.immeSel = word[IMMSEL_BIT];
        d.opCode  = word[OPCODE_LSB +: OPCODE_W];
        d.rd      = word[RD_LSB +: REG_ADDR_W];
        d.ra      = word[RA_LSB +: REG_ADDR_W];
        d.rb      = word[RB_LSB +: REG_ADDR_W];
        return d;
    endfunction

endpackage

// File: rtl/spu_issue_unit_if.sv
// Bus bundle between the upstream fetch stage, the issue unit and the
// decode/register-fetch stage.
//   master : upstream/downstream environment (drives instruction words, stall,
//            flush, writeback; observes ready and issued fields)
//   slave  : the issue unit
interface spu_issue_unit_if;
    import spu_pkg::*;

    logic                  instrValid;
    logic [INSTR_W-1:0]    instrIn;
    logic                  instrReady;
    logic                  flush;
    logic                  stallIn;
    logic                  wbValid;
    logic [REG_ADDR_W-1:0] wbRd;
    logic                  issueValid;
    logic                  immeSelOut;
    logic [OPCODE_W-1:0]   opCodeOut;
    logic [REG_ADDR_W-1:0] rdOut;
    logic [REG_ADDR_W-1:0] raOut;
    logic [REG_ADDR_W-1:0] rbOut;

    modport master (
        output instrValid, instrIn, flush, stallIn, wbValid, wbRd,
        input  instrReady, issueValid, immeSelOut, opCodeOut, rdOut, raOut, rbOut
    );

    modport slave (
        input  instrValid, instrIn, flush, stallIn, wbValid, wbRd,
        output instrReady, issueValid, immeSelOut, opCodeOut, rdOut, raOut, rbOut
    );

endinterface

// File: rtl/issue_fifo.sv
// Instruction FIFO for the issue unit.
//   clk, rstN : clock, asynchronous active-low reset
//   push/din  : write din at the tail (ignored when full)
//   pop       : drop the head (ignored when empty)
//   flush     : empty the FIFO on the next edge; overrides push and pop
//   full/empty: occupancy flags, combinational from the count
//   dout      : current head entry (meaningless while empty)
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module issue_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] din,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] dout
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/spu_issue_unit.sv
// SPU decode/issue front end.
//   clk, rstN : clock, asynchronous active-low reset
//   bus       : spu_issue_unit_if.slave
//     instrValid/instrIn/instrReady : instruction word handshake into the FIFO
//     flush, stallIn                : discard queue / hold issue
//     wbValid, wbRd                 : writeback clearing a scoreboard bit
//     issueValid + field outputs    : registered decode/register-fetch stage
// Parameter DEPTH: FIFO entries (power of two, >= 2).
// Build option: define SPU_ISSUE_SCOREBOARD_EN to enable the 128-entry busy
// scoreboard that holds issue on ra/rb/rd hazards; without it hazard is 0 and
// the writeback inputs are ignored.
module spu_issue_unit
    import spu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              rstN,
    spu_issue_unit_if.slave   bus
);

    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic [INSTR_W-1:0] head;
    decoded_instr_t     head_d;
    logic               hazard;
    logic               issue;
    logic               issue_valid_q;
    decoded_instr_t     fields_q;

    assign push = bus.instrValid && !full && !bus.flush;

    issue_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (INSTR_W)
    ) u_fifo (
        .clk   (clk),
        .rstN  (rstN),
        .push  (push),
        .pop   (pop),
        .flush (bus.flush),
        .din   (bus.instrIn),
        .full  (full),
        .empty (empty),
        .dout  (head)
    );

    assign head_d = decode_instr(head);

`ifdef SPU_ISSUE_SCOREBOARD_EN
    logic [NUM_REGS-1:0] busy;

    // rb is not a source in the immediate form, so it only counts when immeSel = 0.
    assign hazard = busy[head_d.ra]
                  | (!head_d.immeSel & busy[head_d.rb])
                  | busy[head_d.rd];

    // The issue set is written after the writeback clear so it wins on a
    // same-register collision. Flush leaves the vector alone: in-flight
    // instructions still write back.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            busy <= '0;
        end else begin
            if (bus.wbValid) busy[bus.wbRd] <= 1'b0;
            if (issue)       busy[head_d.rd] <= 1'b1;
        end
    end
`else
    logic unused_wb;

    assign hazard    = 1'b0;
    assign unused_wb = ^{bus.wbValid, bus.wbRd};
`endif

    assign issue = !empty && !bus.stallIn && !bus.flush && !hazard;
    assign pop   = issue;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            issue_valid_q <= 1'b0;
            fields_q      <= '0;
        end else begin
            issue_valid_q <= issue;
            if (issue) fields_q <= head_d;
        end
    end

    assign bus.instrReady = !full;
    assign bus.issueValid = issue_valid_q;
    assign bus.immeSelOut = fields_q.immeSel;
    assign bus.opCodeOut  = fields_q.opCode;
    assign bus.rdOut      = fields_q.rd;
    assign bus.raOut      = fields_q.ra;
    assign bus.rbOut      = fields_q.rb;

endmodule

// File: tb/tb_spu_issue_unit.sv
// Directed self-checking bench for spu_issue_unit (DEPTH = 4).
// Expectations that depend on the scoreboard follow SPU_ISSUE_SCOREBOARD_EN.
module tb_spu_issue_unit;

`ifdef SPU_ISSUE_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic clk;
    logic rstN;
    int   passed;
    int   total;

    spu_issue_unit_if bus ();

    spu_issue_unit #(.DEPTH(4)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    function automatic logic [31:0] mk(input logic [5:0] op, input logic imm,
                                       input logic [6:0] rd, input logic [6:0] ra,
                                       input logic [6:0] rb);
        return {op, imm, rd, ra, rb, 4'h0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.instrValid = 1'b0;
        bus.instrIn    = '0;
        bus.flush      = 1'b0;
        bus.stallIn    = 1'b0;
        bus.wbValid    = 1'b0;
        bus.wbRd       = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rstN = 1'b0;
        tick();
        rstN = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({bus.instrReady, bus.issueValid, bus.immeSelOut, bus.opCodeOut, bus.rdOut, bus.raOut, bus.rbOut} !== {1'b1, 1'b0, 1'b0, 6'd0, 21'd0})
            $display("FAIL reset_state: got %0h expected %0h",
                     {bus.instrReady, bus.issueValid, bus.immeSelOut, bus.opCodeOut, bus.rdOut, bus.raOut, bus.rbOut},
                     {1'b1, 1'b0, 1'b0, 6'd0, 21'd0});
        else passed++;
        tick();
        rstN = 1'b1;
        tick();
        total++;
        if ({bus.instrReady, bus.issueValid} !== 2'b10)
            $display("FAIL reset_idle: got %0h expected %0h", {bus.instrReady, bus.issueValid}, 2'b10);
        else passed++;
    endtask

    task automatic test_single_issue();
        do_reset();
        bus.instrValid = 1'b1;
        bus.instrIn    = 32'h14281840;
        tick();
        bus.instrValid = 1'b0;
        total++;
        if (bus.issueValid !== 1'b0)
            $display("FAIL single_pre: got %0h expected %0h", bus.issueValid, 1'b0);
        else passed++;
        tick();
        total++;
        if ({bus.issueValid, bus.immeSelOut, bus.opCodeOut, bus.rdOut, bus.raOut, bus.rbOut} !== {1'b1, 1'b0, 6'h05, 7'd10, 7'd3, 7'd4})
            $display("FAIL single_fields: got %0h expected %0h",
                     {bus.issueValid, bus.immeSelOut, bus.opCodeOut, bus.rdOut, bus.raOut, bus.rbOut},
                     {1'b1, 1'b0, 6'h05, 7'd10, 7'd3, 7'd4});
        else passed++;
        tick();
        total++;
        if ({bus.issueValid, bus.rdOut} !== {1'b0, 7'd10})
            $display("FAIL single_hold: got %0h expected %0h", {bus.issueValid, bus.rdOut}, {1'b0, 7'd10});
        else passed++;
    endtask

    task automatic test_raw_hazard();
        do_reset();
        bus.instrValid = 1'b1;
        bus.instrIn    = 32'h14281840;
        tick();
        bus.instrIn    = mk(6'h01, 1'b0, 7'd11, 7'd10, 7'd0);
        tick();
        bus.instrValid = 1'b0;
        total++;
        if ({bus.issueValid, bus.rdOut} !== {1'b1, 7'd10})
            $display("FAIL raw_first: got %0h expected %0h", {bus.issueValid, bus.rdOut}, {1'b1, 7'd10});
        else passed++;
        tick();
        total++;
        if ({bus.issueValid, bus.rdOut} !== (SB ? {1'b0, 7'd10} : {1'b1, 7'd11}))
            $display("FAIL raw_held: got %0h expected %0h", {bus.issueValid, bus.rdOut}, (SB ? {1'b0, 7'd10} : {1'b1, 7'd11}));
        else passed++;
        tick();
        total++;
        if (bus.issueValid !== 1'b0)
            $display("FAIL raw_held2: got %0h expected %0h", bus.issueValid, 1'b0);
        else passed++;
        bus.wbValid = 1'b1;
        bus.wbRd    = 7'd10;
        tick();
        bus.wbValid = 1'b0;
        total++;
        if (bus.issueValid !== 1'b0)
            $display("FAIL raw_wb_edge: got %0h expected %0h", bus.issueValid, 1'b0);
        else passed++;
        tick();
        total++;
        if ({bus.issueValid, bus.rdOut, bus.raOut} !== {SB, 7'd11, 7'd10})
            $display("FAIL raw_release: got %0h expected %0h", {bus.issueValid, bus.rdOut, bus.raOut}, {SB, 7'd11, 7'd10});
        else passed++;
    endtask

    task automatic test_full_fifo();
        do_reset();
        bus.stallIn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (bus.instrReady !== 1'b1)
                $display("FAIL full_fill_ready: got %0h expected %0h", bus.instrReady, 1'b1);
            else passed++;
            bus.instrValid = 1'b1;
            bus.instrIn    = mk(6'(8 + i), 1'b0, 7'(20 + i), 7'd1, 7'd2);
            tick();
        end
        total++;
        if ({bus.instrReady, bus.issueValid} !== 2'b00)
            $display("FAIL full_flag: got %0h expected %0h", {bus.instrReady, bus.issueValid}, 2'b00);
        else passed++;
        bus.instrIn = mk(6'h3f, 1'b0, 7'd30, 7'd1, 7'd2);
        tick();
        bus.instrValid = 1'b0;
        total++;
        if (bus.instrReady !== 1'b0)
            $display("FAIL full_fifth: got %0h expected %0h", bus.instrReady, 1'b0);
        else passed++;
        bus.stallIn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if ({bus.instrReady, bus.issueValid, bus.opCodeOut, bus.rdOut} !== {1'b1, 1'b1, 6'(8 + i), 7'(20 + i)})
                $display("FAIL full_drain: got %0h expected %0h",
                         {bus.instrReady, bus.issueValid, bus.opCodeOut, bus.rdOut},
                         {1'b1, 1'b1, 6'(8 + i), 7'(20 + i)});
            else passed++;
        end
        tick();
        total++;
        if ({bus.issueValid, bus.rdOut} !== {1'b0, 7'd23})
            $display("FAIL full_empty: got %0h expected %0h", {bus.issueValid, bus.rdOut}, {1'b0, 7'd23});
        else passed++;
    endtask

    task automatic test_immediate();
        do_reset();
        bus.instrValid = 1'b1;
        bus.instrIn    = mk(6'h02, 1'b0, 7'd4, 7'd1, 7'd2);
        tick();
        bus.instrIn    = mk(6'h03, 1'b1, 7'd5, 7'd6, 7'd4);
        tick();
        total++;
        if ({bus.issueValid, bus.rdOut} !== {1'b1, 7'd4})
            $display("FAIL imm_setup: got %0h expected %0h", {bus.issueValid, bus.rdOut}, {1'b1, 7'd4});
        else passed++;
        bus.instrIn    = mk(6'h04, 1'b0, 7'd7, 7'd6, 7'd4);
        tick();
        bus.instrValid = 1'b0;
        total++;
        if ({bus.issueValid, bus.immeSelOut, bus.rdOut, bus.rbOut} !== {1'b1, 1'b1, 7'd5, 7'd4})
            $display("FAIL imm_no_hold: got %0h expected %0h",
                     {bus.issueValid, bus.immeSelOut, bus.rdOut, bus.rbOut}, {1'b1, 1'b1, 7'd5, 7'd4});
        else passed++;
        tick();
        total++;
        if ({bus.issueValid, bus.rdOut} !== (SB ? {1'b0, 7'd5} : {1'b1, 7'd7}))
            $display("FAIL imm_rb_held: got %0h expected %0h", {bus.issueValid, bus.rdOut}, (SB ? {1'b0, 7'd5} : {1'b1, 7'd7}));
        else passed++;
        tick();
        bus.wbValid = 1'b1;
        bus.wbRd    = 7'd4;
        tick();
        bus.wbValid = 1'b0;
        total++;
        if (bus.issueValid !== 1'b0)
            $display("FAIL imm_wb_edge: got %0h expected %0h", bus.issueValid, 1'b0);
        else passed++;
        tick();
        total++;
        if ({bus.issueValid, bus.immeSelOut, bus.rdOut} !== {SB, 1'b0, 7'd7})
            $display("FAIL imm_release: got %0h expected %0h", {bus.issueValid, bus.immeSelOut, bus.rdOut}, {SB, 1'b0, 7'd7});
        else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.instrValid = 1'b1;
            bus.instrIn    = mk(6'(16 + i), 1'b0, 7'(40 + i), 7'd1, 7'd2);
            tick();
            total++;
            if ({bus.issueValid, bus.rdOut} !== ((i == 0) ? {1'b0, 7'd0} : {1'b1, 7'(39 + i)}))
                $display("FAIL b2b_stream: got %0h expected %0h",
                         {bus.issueValid, bus.rdOut}, ((i == 0) ? {1'b0, 7'd0} : {1'b1, 7'(39 + i)}));
            else passed++;
        end
        bus.instrValid = 1'b0;
        tick();
        total++;
        if ({bus.issueValid, bus.opCodeOut, bus.rdOut} !== {1'b1, 6'd19, 7'd43})
            $display("FAIL b2b_last: got %0h expected %0h", {bus.issueValid, bus.opCodeOut, bus.rdOut}, {1'b1, 6'd19, 7'd43});
        else passed++;
        tick();
        total++;
        if (bus.issueValid !== 1'b0)
            $display("FAIL b2b_done: got %0h expected %0h", bus.issueValid, 1'b0);
        else passed++;
    endtask

    task automatic test_flush();
        do_reset();
        bus.instrValid = 1'b1;
        bus.instrIn    = mk(6'h01, 1'b0, 7'd10, 7'd1, 7'd2);
        tick();
        bus.instrValid = 1'b0;
        tick();
        bus.stallIn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.instrValid = 1'b1;
            bus.instrIn    = mk(6'h09, 1'b0, 7'(20 + i), 7'd1, 7'd2);
            tick();
        end
        bus.stallIn = 1'b0;
        bus.flush   = 1'b1;
        bus.instrIn = mk(6'h09, 1'b0, 7'd23, 7'd1, 7'd2);
        tick();
        bus.flush      = 1'b0;
        bus.instrValid = 1'b0;
        total++;
        if ({bus.instrReady, bus.issueValid} !== 2'b10)
            $display("FAIL flush_edge: got %0h expected %0h", {bus.instrReady, bus.issueValid}, 2'b10);
        else passed++;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if ({bus.issueValid, bus.rdOut} !== {1'b0, 7'd10})
                $display("FAIL flush_no_issue: got %0h expected %0h", {bus.issueValid, bus.rdOut}, {1'b0, 7'd10});
            else passed++;
        end
        bus.instrValid = 1'b1;
        bus.instrIn    = mk(6'h07, 1'b0, 7'd12, 7'd10, 7'd3);
        tick();
        bus.instrValid = 1'b0;
        tick();
        total++;
        if ({bus.issueValid, bus.rdOut} !== (SB ? {1'b0, 7'd10} : {1'b1, 7'd12}))
            $display("FAIL flush_busy_kept: got %0h expected %0h", {bus.issueValid, bus.rdOut}, (SB ? {1'b0, 7'd10} : {1'b1, 7'd12}));
        else passed++;
        bus.wbValid = 1'b1;
        bus.wbRd    = 7'd10;
        tick();
        bus.wbValid = 1'b0;
        tick();
        total++;
        if ({bus.issueValid, bus.rdOut} !== {SB, 7'd12})
            $display("FAIL flush_release: got %0h expected %0h", {bus.issueValid, bus.rdOut}, {SB, 7'd12});
        else passed++;
    endtask

    task automatic test_reset_midop();
        do_reset();
        bus.instrValid = 1'b1;
        bus.instrIn    = mk(6'h01, 1'b0, 7'd10, 7'd1, 7'd2);
        tick();
        bus.instrValid = 1'b0;
        tick();
        bus.stallIn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.instrValid = 1'b1;
            bus.instrIn    = mk(6'h09, 1'b0, 7'(20 + i), 7'd1, 7'd2);
            tick();
        end
        bus.instrValid = 1'b0;
        #2;
        rstN = 1'b0;
        #1;
        total++;
        if ({bus.instrReady, bus.issueValid, bus.immeSelOut, bus.opCodeOut, bus.rdOut, bus.raOut, bus.rbOut} !== {1'b1, 1'b0, 1'b0, 6'd0, 21'd0})
            $display("FAIL midreset_async: got %0h expected %0h",
                     {bus.instrReady, bus.issueValid, bus.immeSelOut, bus.opCodeOut, bus.rdOut, bus.raOut, bus.rbOut},
                     {1'b1, 1'b0, 1'b0, 6'd0, 21'd0});
        else passed++;
        bus.stallIn = 1'b0;
        tick();
        rstN = 1'b1;
        bus.instrValid = 1'b1;
        bus.instrIn    = mk(6'h07, 1'b0, 7'd13, 7'd10, 7'd3);
        tick();
        bus.instrValid = 1'b0;
        tick();
        total++;
        if ({bus.issueValid, bus.rdOut, bus.raOut} !== {1'b1, 7'd13, 7'd10})
            $display("FAIL midreset_r10: got %0h expected %0h", {bus.issueValid, bus.rdOut, bus.raOut}, {1'b1, 7'd13, 7'd10});
        else passed++;
        tick();
        total++;
        if (bus.issueValid !== 1'b0)
            $display("FAIL midreset_discard: got %0h expected %0h", bus.issueValid, 1'b0);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rstN   = 1'b0;
        idle_inputs();
        test_reset();
        test_single_issue();
        test_raw_hazard();
        test_full_fifo();
        test_immediate();
        test_back_to_back();
        test_flush();
        test_reset_midop();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
